// File: rtl/bi_piso_serializer.sv
// bi_piso_serializer: parallel-in serial-out shifter with per-word MSB/LSB-first order and gapless back-to-back words
module bi_piso_serializer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         dir,
  input  logic         en,
  output logic         sout,
  output logic         sout_en,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_next;
  logic [N-1:0] shreg;
  logic [CW-1:0] cnt;
  logic ldir, last, accept;
  always_comb begin
    last = state == SHIFT && cnt == CW'(N-1) && en;
    din_ready = state == IDLE || last;
    accept = din_valid && din_ready;
    state_next = accept ? SHIFT : last ? IDLE : state;
    busy = state == SHIFT;
    sout_en = busy && en;
    sout = busy && (ldir ? shreg[0] : shreg[N-1]);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // counter returns to 0 after the last bit so it never exceeds N-1
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shreg <= '0;
      cnt <= '0;
      ldir <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        shreg <= din;
        ldir <= dir;
        cnt <= '0;
      end else if (busy && en) begin
        shreg <= ldir ? shreg >> 1 : shreg << 1;
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
endmodule

// File: doc/bi_piso_serializer.md
BI_PISO_SERIALIZER -- requirements
Module: bi_piso_serializer

Interface
REQ-001 SHALL have parameter N, default 8: parallel word width in bits; legal range N >= 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port din, input, N: parallel word to transmit.
REQ-005 SHALL have port din_valid, input, 1: din holds a word offered for transmission.
REQ-006 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-007 SHALL have port dir, input, 1: bit order, 0 = MSB first, 1 = LSB first; sampled only at word acceptance.
REQ-008 SHALL have port en, input, 1: shift enable; low stalls transmission with no bit lost.
REQ-009 SHALL have port sout, output, 1: serial data bit.
REQ-010 SHALL have port sout_en, output, 1: sout carries a valid bit this cycle; intended to drive a receiver's shift enable.
REQ-011 SHALL have port busy, output, 1: a word is in transmission.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after a word's last bit is sent.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 SHALL hold an N-bit shift register, a latched dir bit and a bit counter of width clog2(N).
REQ-015 SHALL accept a word on any rising edge where din_valid && din_ready is true.
REQ-016 On acceptance, SHALL load din into the shift register, latch dir, clear the counter and enter SHIFT.
REQ-017 SHALL drive din_ready = (state==IDLE) || (state==SHIFT && counter==N-1 && en).
REQ-018 In SHIFT, SHALL drive sout from the shift register: shreg[N-1] when latched dir = 0, shreg[0] when latched dir = 1.
REQ-019 SHALL drive sout, sout_en and busy only from registered state, never combinationally from din, din_valid or dir.
REQ-020 In SHIFT with en = 1, on each edge SHALL shift toward the output end: left when dir = 0, right when dir = 1, filling with 0, and increment the counter.
REQ-021 In SHIFT with en = 0, SHALL hold the shift register, counter and sout, and drive sout_en = 0.
REQ-022 In SHIFT, SHALL drive sout_en = en and busy = 1.
REQ-023 In IDLE, SHALL drive sout = 0, sout_en = 0 and busy = 0.
REQ-024 Timing: word accepted at edge T gives its first bit on sout in cycle T+1; with en held high the last bit is in cycle T+N.
REQ-025 After the edge that shifts out the last bit (counter==N-1 && en), SHALL assert done for exactly one cycle.
REQ-026 After that edge, SHALL return to IDLE unless a new word is accepted on the same edge.
REQ-027 Back-to-back: a word accepted on the last-bit edge SHALL reload, stay in SHIFT, and produce a gapless bit stream; done still pulses for the previous word.
REQ-028 din_valid while busy and not on the last-bit edge SHALL be ignored: din_ready = 0 and no state change.
REQ-029 Changes on dir or din during SHIFT SHALL NOT affect the word in flight.
REQ-030 The counter SHALL wrap to 0 on reload and SHALL never exceed N-1.

Reset
REQ-031 On reset = 0, SHALL immediately, without waiting for clk: force IDLE; clear shift register, counter and latched dir; and drive sout = 0, sout_en = 0, busy = 0, done = 0.
REQ-032 Reset during SHIFT SHALL abandon the word with no done pulse.
REQ-033 The first word after reset release SHALL transmit normally.

Verification
REQ-034 N=8, dir=0, din=8'h1E, en=1 -> sout 0,0,0,1,1,1,1,0 in cycles T+1..T+8; sout_en high 8 cycles; done high at T+9 only; busy low at T+9.
REQ-035 N=8, dir=1, din=8'h1E, en=1 -> sout 0,1,1,1,1,0,0,0 in T+1..T+8; done at T+9; dir toggled mid-frame has no effect.
REQ-036 en low for 3 cycles after 2nd bit -> sout holds bit 2, sout_en=0 during stall; all 8 bits delivered in order; done at T+12.
REQ-037 din_valid held high with words 8'hA5 then 8'h3C, dir=0 -> 16 contiguous bits 10100101 00111100; din_ready high only at T and T+8; done at T+9 and T+17.
REQ-038 Reset asserted asynchronously mid-cycle after 3 bits -> all outputs 0 before next edge, no done; next word after release fully correct.
REQ-039 Loopback into a serial-in bidirectional shift-register model (sout->D, sout_en->en, same dir) -> model holds din after done, for dir=0 and dir=1, 100 random words.
